step_clock_gen: RTL and testbench

//  Front-panel input conditioner for the multi-cycle CPU board build. It debounces
//  the single-step push button into a clean single-step CPU clock and a 1-cycle step

---
 rtl/step_clock_gen.sv | 171 +++++++++++++++++
 tb/tb_step_clock_gen.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/step_clock_gen.sv
// Front-panel conditioner: debounces the single-step button into a clean CPU step
// clock plus a one-cycle strobe, debounces the display-select switches, counts steps.
module step_clock_gen #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn,
  input  logic [1:0]  sw_raw,
  output logic        cpu_clk,
  output logic        step_pulse,
  output logic [1:0]  sw_clean,
  output logic [15:0] step_count
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic                   btn_meta_r;
  logic                   btn_sync_r;
  logic [1:0]             sw_meta_r;
  logic [1:0]             sw_sync_r;

  state_t                 state_r;
  state_t                 state_s;
  logic [CNT_W-1:0]       cnt_r;
  logic [CNT_W-1:0]       cnt_s;
  logic                   cpu_clk_r;
  logic                   cpu_clk_s;
  logic                   step_pulse_r;
  logic                   step_pulse_s;
  logic [15:0]            step_count_r;
  logic [15:0]            step_count_s;

  logic [1:0][CNT_W-1:0]  sw_cnt_r;
  logic [1:0][CNT_W-1:0]  sw_cnt_s;
  logic [1:0]             sw_clean_r;
  logic [1:0]             sw_clean_s;

  // Two-flop synchronisers for the asynchronous front-panel inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta_r <= 1'b0;
      btn_sync_r <= 1'b0;
      sw_meta_r  <= 2'b00;
      sw_sync_r  <= 2'b00;
    end else begin
      btn_meta_r <= btn;
      btn_sync_r <= btn_meta_r;
      sw_meta_r  <= sw_raw;
      sw_sync_r  <= sw_meta_r;
    end
  end

  // Button FSM next-state, strobe and step counter
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    step_pulse_s = 1'b0;
    step_count_s = step_count_r;
    case (state_r)
      IDLE: begin
        if (btn_sync_r) begin
          state_s = PRESS_WAIT;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = IDLE;
        end
      end
      PRESS_WAIT: begin
        if (!btn_sync_r) begin
          state_s = IDLE;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            state_s      = PRESSED;
            step_pulse_s = 1'b1;
            step_count_s = step_count_r + 16'd1;
          end else begin
            state_s = PRESS_WAIT;
          end
        end
      end
      PRESSED: begin
        if (!btn_sync_r) begin
          state_s = RELEASE_WAIT;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = PRESSED;
        end
      end
      RELEASE_WAIT: begin
        if (btn_sync_r) begin
          // release bounce: back to PRESSED without a new strobe
          state_s = PRESSED;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            state_s = IDLE;
          end else begin
            state_s = RELEASE_WAIT;
          end
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
    cpu_clk_s = (state_s == PRESSED) || (state_s == RELEASE_WAIT);
  end

  // Button FSM and registered step outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cnt_r        <= CNT_ZERO;
      cpu_clk_r    <= 1'b0;
      step_pulse_r <= 1'b0;
      step_count_r <= 16'h0000;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      cpu_clk_r    <= cpu_clk_s;
      step_pulse_r <= step_pulse_s;
      step_count_r <= step_count_s;
    end
  end

  // Per-bit switch debounce; any return to the accepted level clears the count
  always_comb begin
    sw_cnt_s   = sw_cnt_r;
    sw_clean_s = sw_clean_r;
    for (int i = 0; i < 2; i++) begin
      if (sw_sync_r[i] == sw_clean_r[i]) begin
        sw_cnt_s[i] = CNT_ZERO;
      end else if (sw_cnt_r[i] == CNT_LAST) begin
        sw_clean_s[i] = sw_sync_r[i];
        sw_cnt_s[i]   = CNT_ZERO;
      end else begin
        sw_cnt_s[i] = sw_cnt_r[i] + CNT_ONE;
      end
    end
  end

  // Switch debounce state and registered clean levels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_cnt_r   <= {(2*CNT_W){1'b0}};
      sw_clean_r <= 2'b00;
    end else begin
      sw_cnt_r   <= sw_cnt_s;
      sw_clean_r <= sw_clean_s;
    end
  end

  assign cpu_clk    = cpu_clk_r;
  assign step_pulse = step_pulse_r;
  assign sw_clean   = sw_clean_r;
  assign step_count = step_count_r;

endmodule

// File: tb/tb_step_clock_gen.sv
// Bench for step_clock_gen: hand-written segment table and corner sequences plus
// randomized stimulus checked cycle by cycle against a run-length reference model.
module tb_step_clock_gen;

  localparam int DC = 4;

  logic        clk;
  logic        rst_n;
  logic        btn;
  logic [1:0]  sw_raw;
  logic        cpu_clk;
  logic        step_pulse;
  logic [1:0]  sw_clean;
  logic [15:0] step_count;

  int checks = 0;
  int errors = 0;

  step_clock_gen #(.DEBOUNCE_CYCLES(DC), .CNT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn        (btn),
    .sw_raw     (sw_raw),
    .cpu_clk    (cpu_clk),
    .step_pulse (step_pulse),
    .sw_clean   (sw_clean),
    .step_count (step_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: inputs delayed two edges, then a level flips once the
  // opposite value has been seen on enough consecutive edges.
  logic [1:0]  m_bdly;
  logic [1:0]  m_sdly1, m_sdly2;
  logic        m_level, m_pulse;
  int          m_run;
  logic [15:0] m_count;
  logic [1:0]  m_clean;
  int          m_swrun [2];

  task automatic model_reset();
    m_bdly = 2'b00; m_sdly1 = 2'b00; m_sdly2 = 2'b00;
    m_level = 1'b0; m_pulse = 1'b0; m_run = 0; m_count = 16'h0000;
    m_clean = 2'b00; m_swrun[0] = 0; m_swrun[1] = 0;
  endtask

  task automatic model_edge();
    m_pulse = 1'b0;
    if (m_bdly[1] != m_level) m_run = m_run + 1;
    else m_run = 0;
    if (m_run == DC + 1) begin
      m_level = ~m_level;
      m_run = 0;
      if (m_level) begin
        m_pulse = 1'b1;
        m_count = m_count + 16'd1;
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (m_sdly2[i] != m_clean[i]) begin
        m_swrun[i] = m_swrun[i] + 1;
        if (m_swrun[i] == DC) begin
          m_clean[i] = m_sdly2[i];
          m_swrun[i] = 0;
        end
      end else begin
        m_swrun[i] = 0;
      end
    end
    m_bdly = {m_bdly[0], btn};
    m_sdly2 = m_sdly1;
    m_sdly1 = sw_raw;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: model steps on the edge, outputs compared on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("cpu_clk", {15'd0, cpu_clk}, {15'd0, m_level});
    check("step_pulse", {15'd0, step_pulse}, {15'd0, m_pulse});
    check("sw_clean", {14'd0, sw_clean}, {14'd0, m_clean});
    check("step_count", step_count, m_count);
  endtask

  typedef struct {
    logic        btn;
    logic [1:0]  sw;
    int          cycles;
    logic        exp_cpu;
    logic [15:0] exp_cnt;
    logic [1:0]  exp_sw;
  } vec_t;

  vec_t vecs [7];
  int   pulses;
  int   first_idx;
  logic cpu_low_seen;

  initial begin
    vecs[0] = '{1'b1, 2'b00, 20, 1'b1, 16'd1, 2'b00};  // clean press
    vecs[1] = '{1'b0, 2'b00, 20, 1'b0, 16'd1, 2'b00};  // clean release
    vecs[2] = '{1'b1, 2'b10,  3, 1'b0, 16'd1, 2'b00};  // short press, switch starts
    vecs[3] = '{1'b0, 2'b10, 10, 1'b0, 16'd1, 2'b10};  // switch accepted
    vecs[4] = '{1'b1, 2'b11,  2, 1'b0, 16'd1, 2'b10};  // 2-cycle switch glitch
    vecs[5] = '{1'b1, 2'b10, 20, 1'b1, 16'd2, 2'b10};  // glitch ignored, second press
    vecs[6] = '{1'b0, 2'b01, 20, 1'b0, 16'd2, 2'b01};  // both switch bits change

    rst_n = 1'b0; btn = 1'b0; sw_raw = 2'b00;
    model_reset();
    #22;
    check("reset_cpu_clk", {15'd0, cpu_clk}, 16'd0);
    check("reset_step_pulse", {15'd0, step_pulse}, 16'd0);
    check("reset_sw_clean", {14'd0, sw_clean}, 16'd0);
    check("reset_step_count", step_count, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 7; v++) begin
      btn = vecs[v].btn;
      sw_raw = vecs[v].sw;
      for (int c = 0; c < vecs[v].cycles; c++) tick();
      check($sformatf("vec%0d_cpu_clk", v), {15'd0, cpu_clk}, {15'd0, vecs[v].exp_cpu});
      check($sformatf("vec%0d_step_count", v), step_count, vecs[v].exp_cnt);
      check($sformatf("vec%0d_sw_clean", v), {14'd0, sw_clean}, {14'd0, vecs[v].exp_sw});
    end

    // Asynchronous reset mid-cycle while the step clock is high
    btn = 1'b1;
    for (int c = 0; c < 10; c++) tick();
    check("pre_reset_cpu_clk", {15'd0, cpu_clk}, 16'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_cpu_clk", {15'd0, cpu_clk}, 16'd0);
    check("async_step_pulse", {15'd0, step_pulse}, 16'd0);
    check("async_sw_clean", {14'd0, sw_clean}, 16'd0);
    check("async_step_count", step_count, 16'd0);
    model_reset();
    btn = 1'b0; sw_raw = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) tick();

    // Reset during PRESS_WAIT, released with the button still held
    btn = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    #2 rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0; first_idx = -1;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (step_pulse) begin
        pulses++;
        if (first_idx < 0) first_idx = n;
      end
    end
    check("rst_mid_press_edge", first_idx[15:0], 16'(DC + 2));
    check("rst_mid_press_pulses", pulses[15:0], 16'd1);
    check("rst_mid_press_count", step_count, 16'd1);
    btn = 1'b0;
    for (int c = 0; c < 12; c++) tick();

    // Press bounce: alternating button never accepted
    pulses = 0; cpu_low_seen = 1'b1;
    for (int c = 0; c < 8; c++) begin
      btn = (c % 2 == 0);
      tick();
      pulses += int'(step_pulse);
      if (cpu_clk) cpu_low_seen = 1'b0;
    end
    btn = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      pulses += int'(step_pulse);
      if (cpu_clk) cpu_low_seen = 1'b0;
    end
    check("bounce_pulses", pulses[15:0], 16'd0);
    check("bounce_cpu_low", {15'd0, cpu_low_seen}, 16'd1);
    check("bounce_count", step_count, 16'd1);

    // Release bounce inside PRESSED gives no second strobe and no clock fall
    pulses = 0;
    btn = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      pulses += int'(step_pulse);
    end
    cpu_low_seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      btn = (c % 2 == 1);
      tick();
      pulses += int'(step_pulse);
      if (!cpu_clk) cpu_low_seen = 1'b1;
    end
    check("rel_bounce_cpu_high", {15'd0, cpu_low_seen}, 16'd0);
    btn = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      pulses += int'(step_pulse);
    end
    check("rel_bounce_pulses", pulses[15:0], 16'd1);
    check("rel_bounce_count", step_count, 16'd2);
    check("rel_bounce_cpu_clk", {15'd0, cpu_clk}, 16'd0);

    // Counter wrap from a preloaded value
    force dut.step_count_r = 16'hFFFE;
    #1 release dut.step_count_r;
    m_count = 16'hFFFE;
    for (int p = 0; p < 2; p++) begin
      btn = 1'b1;
      for (int c = 0; c < 10; c++) tick();
      btn = 1'b0;
      for (int c = 0; c < 10; c++) tick();
      check($sformatf("wrap_step_count%0d", p), step_count, (p == 0) ? 16'hFFFF : 16'h0000);
    end

    // Randomized button/switch activity against the model
    for (int s = 0; s < 400; s++) begin
      int hold;
      btn = 1'($urandom_range(0, 1));
      sw_raw = 2'($urandom_range(0, 3));
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 14) : $urandom_range(1, 6);
      for (int c = 0; c < hold; c++) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
